// File: rtl/prog_loader_if.sv
`timescale 1ns / 1ps
// Byte-stream input and memory write ports of the program loader.
// The host/bench side uses "master", the loader uses "slave".
interface prog_loader_if #(
    parameter int ADDR_W = 9
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              irom_wen;
    logic [ADDR_W-1:0] irom_waddr;
    logic [31:0]       irom_wdata;
    logic              dmem_wen;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [31:0]       dmem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready,
        input  irom_wen, irom_waddr, irom_wdata,
        input  dmem_wen, dmem_waddr, dmem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready,
        output irom_wen, irom_waddr, irom_wdata,
        output dmem_wen, dmem_waddr, dmem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
`timescale 1ns / 1ps
// Framed byte-stream loader for instruction/data memories; holds the processor in reset until a frame checks out.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module prog_loader #(
    parameter int         ADDR_W = 9,
    parameter logic [7:0] HDR    = 8'hA5
`ifdef LOADER_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus,
    output logic         proc_rst,
    output logic         busy,
    output logic         err
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        TGT     = 4'd1,
        ADDR_HI = 4'd2,
        ADDR_LO = 4'd3,
        CNT_HI  = 4'd4,
        CNT_LO  = 4'd5,
        DATA    = 4'd6,
        CHK     = 4'd7,
        RUN     = 4'd8,
        ERR     = 4'd9
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              tgt_q, tgt_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        chk_q, chk_d;
    logic              proc_rst_q, proc_rst_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              irom_wen_q, irom_wen_d;
    logic [ADDR_W-1:0] irom_waddr_q, irom_waddr_d;
    logic [31:0]       irom_wdata_q, irom_wdata_d;
    logic              dmem_wen_q, dmem_wen_d;
    logic [ADDR_W-1:0] dmem_waddr_q, dmem_waddr_d;
    logic [31:0]       dmem_wdata_q, dmem_wdata_d;
    logic [15:0]       pair_s;

`ifdef LOADER_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             in_frame_s;
    assign in_frame_s = (state_q != IDLE) && (state_q != RUN) && (state_q != ERR);
`endif

    // The loader never back-pressures; every offered byte is consumed.
    assign bus.rx_ready   = 1'b1;
    assign bus.irom_wen   = irom_wen_q;
    assign bus.irom_waddr = irom_waddr_q;
    assign bus.irom_wdata = irom_wdata_q;
    assign bus.dmem_wen   = dmem_wen_q;
    assign bus.dmem_waddr = dmem_waddr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign proc_rst       = proc_rst_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign pair_s         = {hi_q, bus.rx_data};

    // Frame parser: next state, word assembly and output strobes.
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        hi_d         = hi_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        word_d       = word_q;
        chk_d        = chk_q;
        proc_rst_d   = proc_rst_q;
        busy_d       = busy_q;
        err_d        = err_q;
        irom_wen_d   = 1'b0;
        irom_waddr_d = irom_waddr_q;
        irom_wdata_d = irom_wdata_q;
        dmem_wen_d   = 1'b0;
        dmem_waddr_d = dmem_waddr_q;
        dmem_wdata_d = dmem_wdata_q;
`ifdef LOADER_TIMEOUT_EN
        tmo_d        = {TMO_W{1'b0}};
`endif
        if (bus.rx_valid) begin
            case (state_q)
                IDLE, RUN, ERR: begin
                    if (bus.rx_data == HDR) begin
                        state_d    = TGT;
                        err_d      = 1'b0;
                        proc_rst_d = 1'b0;
                        busy_d     = 1'b1;
                        chk_d      = 8'h00;
                    end else begin
                        state_d = state_q;
                    end
                end
                TGT: begin
                    chk_d = chk_q ^ bus.rx_data;
                    if ((bus.rx_data == 8'h00) || (bus.rx_data == 8'h01)) begin
                        tgt_d   = bus.rx_data[0];
                        state_d = ADDR_HI;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                ADDR_HI: begin
                    chk_d   = chk_q ^ bus.rx_data;
                    hi_d    = bus.rx_data;
                    state_d = ADDR_LO;
                end
                ADDR_LO: begin
                    chk_d   = chk_q ^ bus.rx_data;
                    addr_d  = pair_s[ADDR_W-1:0];
                    state_d = CNT_HI;
                end
                CNT_HI: begin
                    chk_d   = chk_q ^ bus.rx_data;
                    hi_d    = bus.rx_data;
                    state_d = CNT_LO;
                end
                CNT_LO: begin
                    chk_d = chk_q ^ bus.rx_data;
                    if ((pair_s == 16'd0) || (pair_s > 16'd512)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d   = pair_s;
                        idx_d   = 2'd0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    chk_d = chk_q ^ bus.rx_data;
                    if (idx_q == 2'd3) begin
                        if (tgt_q) begin
                            dmem_wen_d   = 1'b1;
                            dmem_waddr_d = addr_q;
                            dmem_wdata_d = {word_q, bus.rx_data};
                        end else begin
                            irom_wen_d   = 1'b1;
                            irom_waddr_d = addr_q;
                            irom_wdata_d = {word_q, bus.rx_data};
                        end
                        idx_d   = 2'd0;
                        addr_d  = addr_q + ADDR_ONE;
                        cnt_d   = cnt_q - 16'd1;
                        state_d = (cnt_q == 16'd1) ? CHK : DATA;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        word_d = {word_q[15:0], bus.rx_data};
                    end
                end
                CHK: begin
                    busy_d = 1'b0;
                    if (bus.rx_data == chk_q) begin
                        state_d    = RUN;
                        proc_rst_d = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    proc_rst_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
`ifdef LOADER_TIMEOUT_EN
        // A stalled frame is abandoned; any partially assembled word is discarded.
        if (in_frame_s && !bus.rx_valid) begin
            if (tmo_q == TMO_LAST) begin
                state_d    = ERR;
                err_d      = 1'b1;
                busy_d     = 1'b0;
                proc_rst_d = 1'b0;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end else begin
            tmo_d = {TMO_W{1'b0}};
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tgt_q        <= 1'b0;
            hi_q         <= 8'h00;
            addr_q       <= {ADDR_W{1'b0}};
            cnt_q        <= 16'h0000;
            idx_q        <= 2'd0;
            word_q       <= 24'h000000;
            chk_q        <= 8'h00;
            proc_rst_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            irom_wen_q   <= 1'b0;
            irom_waddr_q <= {ADDR_W{1'b0}};
            irom_wdata_q <= 32'h0000_0000;
            dmem_wen_q   <= 1'b0;
            dmem_waddr_q <= {ADDR_W{1'b0}};
            dmem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            hi_q         <= hi_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            chk_q        <= chk_d;
            proc_rst_q   <= proc_rst_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            irom_wen_q   <= irom_wen_d;
            irom_waddr_q <= irom_waddr_d;
            irom_wdata_q <= irom_wdata_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_waddr_q <= dmem_waddr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Inter-byte idle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= {TMO_W{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns / 1ps
// Self-checking bench for prog_loader: directed frames from the test plan plus random frames
// checked against a frame-level model of the expected memory writes and status flags.
module tb_prog_loader;

    typedef logic [7:0] bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct packed {
        logic        tgt;
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    logic proc_rst;
    logic busy;
    logic err;

    int   checks   = 0;
    int   failures = 0;
    int   both_cnt = 0;
    wr_t  obs_q[$];
    wr_t  exp_q[$];

    prog_loader_if #(.ADDR_W(9)) bus ();

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .proc_rst (proc_rst),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.irom_wen && bus.dmem_wen) both_cnt++;
        if (bus.irom_wen) obs_q.push_back({1'b0, bus.irom_waddr, bus.irom_wdata});
        if (bus.dmem_wen) obs_q.push_back({1'b1, bus.dmem_waddr, bus.dmem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bytes(input bq_t b);
        foreach (b[i]) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = b[i];
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    // Sends a frame; just after the header byte the loader must be busy with the processor held.
    task automatic send_frame(input string tag, input bq_t f);
        bq_t h;
        bq_t rest;
        h    = f[0:0];
        rest = f[1:$];
        send_bytes(h);
        chk({tag, "_hdr_busy"}, 64'(busy), 64'd1);
        chk({tag, "_hdr_prst"}, 64'(proc_rst), 64'd0);
        chk({tag, "_hdr_err"}, 64'(err), 64'd0);
        send_bytes(rest);
    endtask

    // Model: frame bytes from its fields; CHK is the XOR of everything after HDR.
    function automatic bq_t make_frame(input logic [7:0] tgt, input logic [15:0] addr,
                                       input wq_t words, input logic [7:0] chk_flip);
        bq_t  f;
        logic [7:0] x;
        int   n;
        n = words.size();
        f = {8'hA5, tgt, addr[15:8], addr[7:0], 8'(n >> 8), 8'(n & 255)};
        foreach (words[i]) begin
            f.push_back(words[i][31:24]);
            f.push_back(words[i][23:16]);
            f.push_back(words[i][15:8]);
            f.push_back(words[i][7:0]);
        end
        x = 8'h00;
        for (int i = 1; i < f.size(); i++) x = x ^ f[i];
        f.push_back(x ^ chk_flip);
        return f;
    endfunction

    // Model: word i goes to (start + i) mod 512.
    task automatic add_exp(input logic tgt, input logic [15:0] addr, input wq_t words);
        wr_t e;
        int  a;
        foreach (words[i]) begin
            a      = (int'(addr) + i) % 512;
            e.tgt  = tgt;
            e.addr = a[8:0];
            e.data = words[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic check_writes(input string tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_flags(input string tag, input logic pr, input logic b, input logic e);
        chk({tag, "_prst"}, 64'(proc_rst), 64'(pr));
        chk({tag, "_busy"}, 64'(busy), 64'(b));
        chk({tag, "_err"}, 64'(err), 64'(e));
    endtask

    initial begin
        bq_t        f;
        bq_t        part;
        wq_t        w;
        logic [15:0] a;
        logic       t;
        logic [7:0] flip;
        logic [7:0] jb;

        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_ready", 64'(bus.rx_ready), 64'd1);
        chk("reset_iwen", 64'(bus.irom_wen), 64'd0);
        chk("reset_dwen", 64'(bus.dmem_wen), 64'd0);
        chk("reset_iaddr", 64'(bus.irom_waddr), 64'd0);
        chk("reset_idata", 64'(bus.irom_wdata), 64'd0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_flags("idle", 1'b0, 1'b0, 1'b0);
        check_writes("idle");

        // Single irom word, literal frame bytes.
        f = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_frame("f1", f);
        exp_q.push_back({1'b0, 9'd0, 32'h12345678});
        check_flags("f1", 1'b1, 1'b0, 1'b0);
        check_writes("f1");

        // dmem pair across the address wrap.
        w = {32'hAABBCCDD, 32'h11223344};
        send_frame("f2", make_frame(8'h01, 16'h01FF, w, 8'h00));
        add_exp(1'b1, 16'h01FF, w);
        check_flags("f2", 1'b1, 1'b0, 1'b0);
        check_writes("f2");

        // Bad checksum: write lands, error raised, processor held.
        f = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_frame("badchk", f);
        exp_q.push_back({1'b0, 9'd0, 32'h12345678});
        check_flags("badchk", 1'b0, 1'b0, 1'b1);
        check_writes("badchk");
        w = {32'hCAFEF00D};
        send_frame("recover", make_frame(8'h00, 16'h0010, w, 8'h00));
        add_exp(1'b0, 16'h0010, w);
        check_flags("recover", 1'b1, 1'b0, 1'b0);
        check_writes("recover");

        // Illegal target, zero count and oversize count all abort without writes.
        send_frame("tgt2", {8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09});
        check_flags("tgt2", 1'b0, 1'b0, 1'b1);
        check_writes("tgt2");
        send_frame("cnt0", {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
        check_flags("cnt0", 1'b0, 1'b0, 1'b1);
        check_writes("cnt0");
        send_frame("cnt513", {8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
        check_flags("cnt513", 1'b0, 1'b0, 1'b1);
        check_writes("cnt513");
        send_bytes({8'h00, 8'hFF});
        check_flags("junk", 1'b0, 1'b0, 1'b1);
        w = {32'h01020304, 32'hA5A5A5A5};
        send_frame("after_junk", make_frame(8'h01, 16'hFE05, w, 8'h00));
        add_exp(1'b1, 16'hFE05, w);
        check_flags("after_junk", 1'b1, 1'b0, 1'b0);
        check_writes("after_junk");

        // Maximum count: 512 words filling the whole memory from 100 with wrap.
        w.delete();
        for (int i = 0; i < 512; i++) w.push_back($urandom());
        send_frame("n512", make_frame(8'h00, 16'd100, w, 8'h00));
        add_exp(1'b0, 16'd100, w);
        check_flags("n512", 1'b1, 1'b0, 1'b0);
        check_writes("n512");

        // Random frames with leading junk and occasional corrupted checksum.
        for (int k = 0; k < 20; k++) begin
            part.delete();
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h00;
                part.push_back(jb);
            end
            send_bytes(part);
            t = 1'($urandom_range(0, 1));
            a = 16'($urandom());
            if ($urandom_range(0, 3) == 0) a[8:0] = 9'h1FE;
            w.delete();
            for (int j = 0; j < $urandom_range(1, 5); j++) w.push_back($urandom());
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame($sformatf("rnd%0d", k), make_frame({7'd0, t}, a, w, flip));
            add_exp(t, a, w);
            check_flags($sformatf("rnd%0d", k), flip == 8'h00, 1'b0, flip != 8'h00);
            check_writes($sformatf("rnd%0d", k));
        end

        // Asynchronous reset after two data bytes.
        f    = make_frame(8'h00, 16'h0005, {32'h12345678}, 8'h00);
        part = f[7:$];
        send_frame("rstmid", f[0:7]);
        #2;
        rst = 1'b0;
        #1;
        check_flags("rstmid", 1'b0, 1'b0, 1'b0);
        chk("rstmid_iaddr", 64'(bus.irom_waddr), 64'd0);
        chk("rstmid_idata", 64'(bus.irom_wdata), 64'd0);
        chk("rstmid_ready", 64'(bus.rx_ready), 64'd1);
        obs_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_bytes(part[0:1]);
        check_flags("rstmid_after", 1'b0, 1'b0, 1'b0);
        check_writes("rstmid_after");

        // Long stall mid-DATA.
        f    = make_frame(8'h00, 16'h0007, {32'hDEADBEEF}, 8'h00);
        part = f[8:$];
        send_frame("stall", f[0:7]);
        repeat (1100) @(posedge clk);
        #1;
`ifdef LOADER_TIMEOUT_EN
        check_flags("stall_tmo", 1'b0, 1'b0, 1'b1);
        send_bytes(part);
        check_flags("stall_tmo_after", 1'b0, 1'b0, 1'b1);
        check_writes("stall_tmo");
`else
        check_flags("stall_wait", 1'b0, 1'b1, 1'b0);
        send_bytes(part);
        exp_q.push_back({1'b0, 9'd7, 32'hDEADBEEF});
        check_flags("stall_done", 1'b1, 1'b0, 1'b0);
        check_writes("stall_done");
`endif

        chk("one_hot_wen", 64'(both_cnt), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
